ram_stream_reader: RTL
======================

Name: ram_stream_reader

Overview:
Read-side controller for the small register-file RAMs (RAMnxm: write port WADDR/WDATA/WE, combinational read port RADDR/RDATA).
- On START, walks LEN consecutive addresses from BASE, wrapping modulo depth.
- Streams each word out on a valid/ready interface at up to one word per cycle, then pulses DONE.
- It is the reader counterpart to the counter-driven writers that fill these RAMs.

Parameters:
ADDR_W, 2, RAM address width; depth = 2^ADDR_W
DATA_W, 1, RAM word width

Ports:
CLK  input  1  clock, rising edge
ASYNCRESET  input  1  asynchronous, active-high reset
START  input  1  begin a burst; sampled only in IDLE
BASE  input  ADDR_W  first address; sampled with START
LEN  input  ADDR_W+1  words to read, 0..2^ADDR_W; sampled with START
RADDR  output  ADDR_W  RAM read address (drives RAM RADDR)
RDATA  input  DATA_W  RAM read data, combinational from RADDR
O_DATA  output  DATA_W  streamed word, registered
O_VALID  output  1  O_DATA valid
O_READY  input  1  consumer accepts O_DATA when O_VALID & O_READY at a rising edge
BUSY  output  1  high in any state other than IDLE
DONE  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high on ASYNCRESET.
- On reset assertion, without waiting for a clock edge:
  - state = IDLE;
  - address register = 0, so RADDR = 0;
  - remaining = 0;
  - O_DATA = 0, O_VALID = 0, BUSY = 0, DONE = 0.
- Reset applies mid-burst too. The burst is abandoned and no DONE pulse is issued.
- RADDR always equals the address register. There is no combinational path from any input to RADDR.
- States, all outputs registered:
  - IDLE:
    - START=1 and LEN≠0: load addr=BASE, remaining=LEN, go to LOAD.
    - START=1 and LEN=0: go to FINISH; no data is emitted.
    - START=0: stay in IDLE.
  - LOAD, one cycle:
    - O_DATA ← RDATA (read at addr); O_VALID ← 1;
    - addr ← addr+1 mod 2^ADDR_W; remaining ← remaining−1;
    - go to STREAM.
  - STREAM, O_VALID=1:
    - O_READY=0: hold O_DATA, addr and remaining unchanged. O_DATA must not change while O_VALID=1 and O_READY=0.
    - O_READY=1 and remaining≠0: O_DATA ← RDATA, addr ← addr+1 (wraps), remaining−1; stay in STREAM.
    - O_READY=1 and remaining=0: O_VALID ← 0; go to FINISH.
  - FINISH: DONE=1 for exactly one cycle; go to IDLE.
- Latency, counting from the edge that samples START (E0):
  - first word valid after E1;
  - full throughput is one word per cycle while O_READY=1;
  - DONE is high in the cycle after the edge that accepts the last word;
  - BUSY drops together with DONE.
  - For LEN=0, DONE is high in the cycle after E0.
- START asserted while BUSY=1 is ignored; BASE and LEN are not re-sampled.
- Address wrap: the increment is modulo 2^ADDR_W. LEN=2^ADDR_W reads every word once, starting at BASE.
- Write collision: the RAM write port runs concurrently. A capture on the same edge as a write to the same address returns the pre-write value. A later capture returns the new value.
- remaining is ADDR_W+1 bits wide and never underflows.

Decomposition:
- Shared package holds:
  - the state encoding constants: IDLE=0, LOAD=1, STREAM=2, FINISH=3, 2-bit;
  - the LEN width rule, ADDR_W+1.
- One sub-module: ram_reader_addr_counter.
  - ADDR_W-bit register with synchronous load (BASE), count-enable increment with wrap, and asynchronous reset to 0.
  - It provides RADDR.
- FSM, remaining counter and output register live in the top level.

Test Plan:
- Reset: assert ASYNCRESET between clock edges → immediately O_VALID=0, DONE=0, BUSY=0, RADDR=0, O_DATA=0.
- Basic burst: RAM preloaded [1,0,1,1], ADDR_W=2, DATA_W=1, BASE=0, LEN=4, O_READY=1.
  - O_DATA = 1,0,1,1 on four consecutive cycles starting after E1.
  - DONE pulses the following cycle; BUSY=0 after it.
- Backpressure: same burst, O_READY=0 for 3 cycles at the second word → O_DATA holds 0 with O_VALID=1, and RADDR stays at 2. The stream then resumes 1,1, and DONE pulses once.
- Wrap and zero length:
  - BASE=3, LEN=3 → RADDR sequence 3,0,1 and O_DATA = 1,1,0.
  - LEN=0 → DONE pulses in the cycle after E0, with no O_VALID.
- Mid-burst disturbances:
  - START pulsed during STREAM → ignored; the burst completes unchanged.
  - ASYNCRESET during STREAM → O_VALID drops at once, with no DONE pulse.
  - A new START after reset works normally.
- Write collision: WE=1, WADDR=1, WDATA=1 on the edge capturing addr 1 (old value 0) → O_DATA=0. A second burst then reads 1 at addr 1.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: state encoding and the burst-length width rule.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_t;

  // LEN must express 0..2^addr_w, so it needs one bit more than the address.
  function automatic int unsigned len_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/ram_reader_addr_counter.sv
// Read-address register for the stream reader: load with the burst base, step with wrap.
module ram_reader_addr_counter #(
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr
);

  // Natural overflow of the ADDR_W-bit add gives the modulo-depth wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader for a combinational-read register-file RAM; streams LEN words from BASE on valid/ready.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 1
) (
  input  logic                               CLK,
  input  logic                               ASYNCRESET,
  input  logic                               START,
  input  logic [ADDR_W-1:0]                  BASE,
  input  logic [len_width(ADDR_W)-1:0]       LEN,
  output logic [ADDR_W-1:0]                  RADDR,
  input  logic [DATA_W-1:0]                  RDATA,
  output logic [DATA_W-1:0]                  O_DATA,
  output logic                               O_VALID,
  input  logic                               O_READY,
  output logic                               BUSY,
  output logic                               DONE
);

  localparam int unsigned LEN_W = len_width(ADDR_W);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               addr_load_c;
  logic               addr_inc_c;

  ram_reader_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk  (CLK),
    .rst  (ASYNCRESET),
    .load (addr_load_c),
    .inc  (addr_inc_c),
    .base (BASE),
    .addr (RADDR)
  );

  // Next-state, remaining-count and output-register values.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    data_d      = data_q;
    valid_d     = valid_q;
    addr_load_c = 1'b0;
    addr_inc_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          if (LEN != '0) begin
            addr_load_c = 1'b1;
            rem_d       = LEN;
            state_d     = LOAD;
          end else begin
            state_d = FINISH;
          end
        end
      end
      LOAD: begin
        data_d     = RDATA;
        valid_d    = 1'b1;
        addr_inc_c = 1'b1;
        rem_d      = rem_q - LEN_W'(1);
        state_d    = STREAM;
      end
      STREAM: begin
        // Without O_READY everything holds, so O_DATA is stable while offered.
        if (O_READY) begin
          if (rem_q != '0) begin
            data_d     = RDATA;
            addr_inc_c = 1'b1;
            rem_d      = rem_q - LEN_W'(1);
          end else begin
            valid_d = 1'b0;
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign O_DATA  = data_q;
  assign O_VALID = valid_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule
